// File: rtl/multiword_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial multiword adder.
// Optional SUBTRACT_MODE_EN adds a subtract path in the interface and controller.
package multiword_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-nibble build still needs a one-bit index register.
  function automatic int idx_width(input int num_nibbles);
    return (num_nibbles <= 1) ? 1 : $clog2(num_nibbles);
  endfunction

endpackage

// File: rtl/multiword_adder_ctrl_if.sv
// Operand/result valid-ready bundle for multiword_adder_ctrl.
// With SUBTRACT_MODE_EN defined, an extra 'sub' request bit travels with the operands.
interface multiword_adder_ctrl_if #(
  parameter int NUM_NIBBLES = 4
);
  import multiword_adder_pkg::*;

  localparam int W = NIBBLE_W * NUM_NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SUBTRACT_MODE_EN
  logic         sub;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif

endinterface

// File: rtl/multiword_adder_ctrl_ripple_adder.sv
// 4-bit ripple-carry adder built from explicit full-adder equations.
// This is the only arithmetic element used by multiword_adder_ctrl.
module ripple_adder
  import multiword_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] carry;

  always_comb begin
    sum      = '0;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[NIBBLE_W];
  end

endmodule

// File: rtl/multiword_adder_ctrl.sv
// Nibble-serial wide adder: one shared ripple_adder, carry fed back through carry_r.
// Define SUBTRACT_MODE_EN to add the 'sub' request (a - b via inverted b and carry-in 1).
module multiword_adder_ctrl
  import multiword_adder_pkg::*;
#(
  parameter int NUM_NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  multiword_adder_ctrl_if.slave bus
);

  localparam int W     = NIBBLE_W * NUM_NIBBLES;
  localparam int IDX_W = idx_width(NUM_NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIBBLES - 1);

  state_t              state;
  state_t              state_nxt;
  logic [W-1:0]        a_r;
  logic [W-1:0]        b_r;
  logic [W-1:0]        sum_r;
  logic                carry_r;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W+1:0]    bit_base;
  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] add_sum;
  logic                add_cout;
  logic                accept;
`ifdef SUBTRACT_MODE_EN
  logic                sub_r;
`endif

  assign accept   = (state == IDLE) && bus.in_valid;
  assign bit_base = {idx, 2'b00};

  // Select the current nibble of each latched operand for the shared adder.
  always_comb begin
    a_nib = a_r[bit_base +: NIBBLE_W];
`ifdef SUBTRACT_MODE_EN
    b_nib = sub_r ? ~b_r[bit_base +: NIBBLE_W] : b_r[bit_base +: NIBBLE_W];
`else
    b_nib = b_r[bit_base +: NIBBLE_W];
`endif
  end

  ripple_adder u_adder (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_r),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ADD;
      ADD:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and per-nibble accumulation; DONE leaves everything frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
`ifdef SUBTRACT_MODE_EN
      sub_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r <= bus.a;
            b_r <= bus.b;
            idx <= '0;
`ifdef SUBTRACT_MODE_EN
            sub_r   <= bus.sub;
            carry_r <= bus.sub ? 1'b1 : bus.cin;
`else
            carry_r <= bus.cin;
`endif
          end
        end
        ADD: begin
          sum_r[bit_base +: NIBBLE_W] <= add_sum;
          carry_r                     <= add_cout;
          if (idx != LAST_IDX) begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.cout      = carry_r;

endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// Directed self-checking bench for multiword_adder_ctrl with NUM_NIBBLES=4 (16-bit operands).
// Subtract vectors run only when SUBTRACT_MODE_EN is defined.
module tb_multiword_adder_ctrl;

  localparam int NUM_NIBBLES = 4;
  localparam int W           = 4 * NUM_NIBBLES;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multiword_adder_ctrl_if #(.NUM_NIBBLES(NUM_NIBBLES)) bus ();

  multiword_adder_ctrl #(.NUM_NIBBLES(NUM_NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present an operand set and hold it until the accept edge, then scramble the inputs.
  task automatic applyStimulus(input string tag, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                               input logic cin_v, input logic sub_v);
    int accepted;
    bus.a        = a_v;
    bus.b        = b_v;
    bus.cin      = cin_v;
`ifdef SUBTRACT_MODE_EN
    bus.sub      = sub_v;
`endif
    bus.in_valid = 1'b1;
    accepted     = 0;
    for (int i = 0; i < 40 && accepted == 0; i++) begin
      if (bus.in_ready) accepted = 1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.a        = 16'hDEAD;
    bus.b        = 16'hBEEF;
    bus.cin      = ~cin_v;
`ifdef SUBTRACT_MODE_EN
    bus.sub      = ~sub_v;
`endif
    checkOutput({tag, "_accept"}, 32'(accepted), 32'd1);
  endtask

  // Count edges from the accept edge until out_valid is seen (bounded).
  task automatic waitResult(input string tag);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(NUM_NIBBLES));
  endtask

  task automatic runCase(input string tag, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                         input logic cin_v, input logic sub_v,
                         input logic [W-1:0] exp_sum, input logic exp_cout);
    applyStimulus(tag, a_v, b_v, cin_v, sub_v);
    waitResult(tag);
    checkOutput({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
    checkOutput({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
    @(posedge clk);
    #1;
    checkOutput({tag, "_back_idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
`ifdef SUBTRACT_MODE_EN
    bus.sub       = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_sum", 32'(bus.sum), 32'h0);
    checkOutput("reset_cout", 32'(bus.cout), 32'd0);

    runCase("add_small", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0);
    runCase("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    runCase("add_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0);
    runCase("add_max", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);

    // Backpressure: result must hold while new operands are offered and ignored.
    bus.out_ready = 1'b0;
    applyStimulus("bp", 16'h1111, 16'h2222, 1'b0, 1'b0);
    bus.a        = 16'h5555;
    bus.b        = 16'h0001;
    bus.cin      = 1'b0;
`ifdef SUBTRACT_MODE_EN
    bus.sub      = 1'b0;
`endif
    bus.in_valid = 1'b1;
    checkOutput("bp_ready_in_add", 32'(bus.in_ready), 32'd0);
    waitResult("bp");
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("bp_hold_sum", 32'(bus.sum), 32'h3333);
      checkOutput("bp_hold_cout", 32'(bus.cout), 32'd0);
      checkOutput("bp_hold_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("bp_release_ready", 32'(bus.in_ready), 32'd1);
    runCase("bp_next", 16'h5555, 16'h0001, 1'b0, 1'b0, 16'h5556, 1'b0);

    // Reset during the second ADD cycle discards the partial result.
    applyStimulus("rst_mid", 16'hABCD, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_mid_sum", 32'(bus.sum), 32'h0);
    checkOutput("rst_mid_cout", 32'(bus.cout), 32'd0);
    checkOutput("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    runCase("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0);

`ifdef SUBTRACT_MODE_EN
    runCase("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
    runCase("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    runCase("sub_equal", 16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1);
    runCase("add_after_sub", 16'h0007, 16'h0005, 1'b0, 1'b0, 16'h000C, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiword_adder_ctrl.md
Name: multiword_adder_ctrl

Overview:
- Sequencer that reuses one 4-bit ripple-carry adder to add wide operands over several cycles, one nibble per cycle, LSB nibble first.
- Carry-out from each nibble is registered and fed back as carry-in for the next nibble.
- Sits between a valid/ready operand source and a valid/ready result sink.
- Trades latency for area in arithmetic datapaths that cannot afford a full-width adder.

Parameters:
- NUM_NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NUM_NIBBLES; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand set present
- in_ready  output  1  controller can accept operands (high only in IDLE)
- a  input  W  operand A
- b  input  W  operand B
- cin  input  1  initial carry-in
- out_valid  output  1  result available
- out_ready  input  1  sink accepts result
- sum  output  W  result
- cout  output  1  final carry-out

Behaviour:
- Clocking: single clock domain. Reset is synchronous and active-high on rst.
- Reset: state=IDLE; in_ready=1 on the cycle after reset releases; out_valid=0, sum=0, cout=0; internal operand, carry and index registers=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, cin into a_r, b_r, carry_r; idx<=0; go to ADD.
  - ADD: in_ready=0. Adder inputs are nibble idx of a_r and b_r plus carry_r. On each edge, sum_r[4*idx+:4] <= adder sum, carry_r <= adder carry-out, idx <= idx+1. When idx==NUM_NIBBLES-1, go to DONE instead of incrementing.
  - DONE: out_valid=1; sum=sum_r and cout=carry_r held stable. On out_ready, go to IDLE and clear out_valid.
- Latency: the accept edge is k; out_valid is high from edge k+NUM_NIBBLES. With out_ready tied high, a new accept is possible every NUM_NIBBLES+2 cycles.
- Handshakes:
  - in_valid while busy (ADD or DONE) is ignored. No buffering; the source must hold its data.
  - out_valid is never withdrawn without out_ready. sum and cout must not change while out_valid=1 and out_ready=0.
  - No same-cycle result-release and new-accept: in_ready rises only in IDLE.
- Arithmetic: unsigned modulo 2^W; cout is the true carry out of bit W-1. The carry ripples across nibbles only through carry_r, never combinationally across cycles.
- Boundaries:
  - rst asserted mid-ADD or in DONE: the partial result is discarded and the block returns to IDLE the next cycle.
  - Operands changing on a/b after the accept edge have no effect.

Optional Feature:
- Macro SUBTRACT_MODE_EN.
- Defined:
  - Adds input port sub (1 bit), sampled at the accept edge.
  - When sub=1, the adder uses ~b_r nibbles, and carry_r is initialised to 1 regardless of cin.
  - Result = a-b mod 2^W; cout=1 means no borrow, cout=0 means borrow.
- Undefined: the sub port is absent and the block is add-only.

Decomposition:
- Package multiword_adder_pkg:
  - state enum IDLE/ADD/DONE (2-bit encoding)
  - NIBBLE_W=4 constant
  - function computing the idx width as clog2(NUM_NIBBLES)
- Sub-module: instantiate the existing 4-bit ripple_adder as the only arithmetic element. The controller holds only registers and muxing; no extra adders are inferred.

Test Plan:
- 0x0001+0x0002, cin=0, out_ready=1 -> sum=0x0003, cout=0; out_valid rises exactly 4 cycles after the accept edge.
- 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1 (carry propagates through all 4 nibble steps). Also 0x1234+0x4321, cin=1 -> sum=0x5556, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE; pulse in_valid with new operands during ADD/DONE -> sum/cout stable, in_ready=0, the new operands are not taken. Release out_ready -> IDLE next cycle, then the new set is accepted.
- Reset mid-operation: assert rst at the 2nd ADD cycle of 0xABCD+0x1111 -> next cycle out_valid=0, sum=0, cout=0, in_ready=1. A subsequent 0x0F0F+0x00F1 -> 0x1000, cout=0.
- SUBTRACT_MODE_EN:
  - 0x0005-0x0007 -> sum=0xFFFE, cout=0.
  - 0x0007-0x0005 -> sum=0x0002, cout=1.
  - cin=0 is ignored when sub=1.
